// File: rtl/tick_pulse_gen.sv
// rtl/tick_pulse_gen.sv - multi-channel tick enables, divided square waves and power-on start pulse
//
// Purpose: derives per-channel clock enables (periodic or one-shot) and toggling
// square waves from the single system clock, plus a one-time start pulse after reset.
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high
//   enable    global run enable for all channels (start sequencer unaffected)
//   period    channel i period at [i*CNT_W +: CNT_W]; 0 disables the channel
//   mode      per channel: 0 = periodic, 1 = one-shot
//   trigger   per channel one-shot launch (ignored in periodic mode)
//   tick      one-cycle registered pulse per channel event
//   slow_clk  toggles on every tick of the channel
//   start     power-on start pulse
//   busy      OR of all armed one-shot channels

module tick_pulse_gen #(
   parameter int CHANNELS    = 2,
   parameter int CNT_W       = 16,
   parameter int START_DELAY = 5,
   parameter int START_WIDTH = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [CHANNELS*CNT_W-1:0] period,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS-1:0]       trigger,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       slow_clk,
   output logic                      start,
   output logic                      busy
);

   localparam int               SW        = $clog2(START_DELAY + START_WIDTH + 1);
   localparam logic [SW-1:0]    START_LO  = SW'(START_DELAY);
   localparam logic [SW-1:0]    START_END = SW'(START_DELAY + START_WIDTH);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic [CHANNELS-1:0][CNT_W-1:0] per;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_n;
   logic [CHANNELS-1:0]            armed;
   logic [CHANNELS-1:0]            armed_n;
   logic [CHANNELS-1:0]            mode_q;
   logic [CHANNELS-1:0]            tick_n;
   logic [CHANNELS-1:0]            slow_n;
   logic [SW-1:0]                  scnt;
   logic [SW-1:0]                  scnt_n;
   logic                           start_n;

   assign per  = period;
   assign busy = |armed;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_n[i]   = cnt[i];
         armed_n[i] = armed[i];
         tick_n[i]  = 1'b0;
         slow_n[i]  = slow_clk[i];
         if (per[i] == '0) begin
            cnt_n[i]   = '0;
            armed_n[i] = 1'b0;
         end else if (mode[i] != mode_q[i]) begin
            // mode switch restarts the channel cleanly, no tick on this edge
            cnt_n[i]   = '0;
            armed_n[i] = 1'b0;
         end else if (!mode[i]) begin
            if (enable) begin
               // >= rather than == so a period shrunk below the current count
               // expires on the next edge instead of wrapping through 2^CNT_W
               if (cnt[i] >= per[i] - ONE) begin
                  cnt_n[i]  = '0;
                  tick_n[i] = 1'b1;
                  slow_n[i] = ~slow_clk[i];
               end else begin
                  cnt_n[i] = cnt[i] + ONE;
               end
            end
         end else if (trigger[i]) begin
            // trigger wins over an expiring count: restart, tick suppressed;
            // sampled even when enable is low
            armed_n[i] = 1'b1;
            cnt_n[i]   = '0;
         end else if (armed[i] && enable) begin
            if (cnt[i] >= per[i] - ONE) begin
               cnt_n[i]   = '0;
               armed_n[i] = 1'b0;
               tick_n[i]  = 1'b1;
               slow_n[i]  = ~slow_clk[i];
            end else begin
               cnt_n[i] = cnt[i] + ONE;
            end
         end
      end
   end

   // start counter saturates at DELAY+WIDTH; first released edge counts as 1
   always_comb begin
      scnt_n  = (scnt == START_END) ? scnt : scnt + SW'(1);
      start_n = (scnt_n >= START_LO) && (scnt_n < START_END);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         armed    <= '0;
         tick     <= '0;
         slow_clk <= '0;
         mode_q   <= mode;   // avoid a spurious mode-change event right after reset
         scnt     <= '0;
         start    <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         armed    <= armed_n;
         tick     <= tick_n;
         slow_clk <= slow_n;
         mode_q   <= mode;
         scnt     <= scnt_n;
         start    <= start_n;
      end
   end

endmodule
